// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - state encoding and sizing helper shared by the shift-add multiplier
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) bits++;
      return bits;
   endfunction

endpackage

// File: rtl/seq_multiplier_step.sv
// rtl/seq_multiplier_step.sv - one combinational add-and-shift row of the shift-add multiplier
module seq_multiplier_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] mag_m_i,
   input  logic [WIDTH-1:0] mag_q_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] mag_q_o
);

   logic [WIDTH:0] sum;

   // The carry out of the add becomes the new accumulator MSB after the shift.
   assign sum = mag_q_i[0] ? ({1'b0, acc_i} + {1'b0, mag_m_i}) : {1'b0, acc_i};
   assign {acc_o, mag_q_o} = {sum, mag_q_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative signed/unsigned shift-add multiplier with valid/ready handshakes
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   m,
   input  logic [WIDTH-1:0]   q,
   input  logic               sgn,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mag_m_q, mag_m_d;
   logic [WIDTH-1:0] mag_q_q, mag_q_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    product_q, product_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic [WIDTH-1:0] step_acc, step_mag_q;
   logic [PW-1:0]    full;

   seq_multiplier_step #(.WIDTH(WIDTH)) u_step (
      .acc_i   (acc_q),
      .mag_m_i (mag_m_q),
      .mag_q_i (mag_q_q),
      .acc_o   (step_acc),
      .mag_q_o (step_mag_q)
   );

   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign full      = {acc_q, mag_q_q};
   assign out_valid = out_valid_q;
   assign product   = product_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mag_m_d     = mag_m_q;
      mag_q_d     = mag_q_q;
      neg_d       = neg_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_CALC: begin
            acc_d   = step_acc;
            mag_q_d = step_mag_q;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_SIGN;
         end
         ST_SIGN: begin
            product_d   = neg_q ? (~full + PW'(1)) : full;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Capture overrides the IDLE/DONE transitions above, giving back-to-back issue from DONE.
      if (accept) begin
         mag_m_d = (sgn && m[WIDTH-1]) ? (~m + WIDTH'(1)) : m;
         mag_q_d = (sgn && q[WIDTH-1]) ? (~q + WIDTH'(1)) : q;
         neg_d   = sgn & (m[WIDTH-1] ^ q[WIDTH-1]);
         acc_d   = '0;
         cnt_d   = CW'(WIDTH);
         state_d = ST_CALC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mag_m_q     <= '0;
         mag_q_q     <= '0;
         neg_q       <= 1'b0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mag_m_q     <= mag_m_d;
         mag_q_q     <= mag_q_d;
         neg_q       <= neg_d;
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=13
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid[2], out_ready[2], sgn[2], in_ready[2], out_valid[2];
   logic [12:0] m[2], q[2];
   logic [15:0] p8;
   logic [25:0] p13;
   logic [25:0] prod[2];

   int  checks = 0;
   int  passes = 0;
   bit  chk_en = 1'b0;

   // Behavioural model state: an accepted job matures WIDTH+1 edges later.
   bit          busy[2], ev[2];
   int          rem[2], nacc[2];
   logic [25:0] pend[2] = '{26'd0, 26'd0};
   logic [25:0] ep[2]   = '{26'd0, 26'd0};

   always #5 clk = ~clk;

   assign prod[0] = {10'd0, p8};
   assign prod[1] = p13;

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .m(m[0][7:0]), .q(q[0][7:0]), .sgn(sgn[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .product(p8)
   );

   seq_multiplier #(.WIDTH(13)) dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .m(m[1]), .q(q[1]), .sgn(sgn[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .product(p13)
   );

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 13;
   endfunction

   function automatic logic [25:0] ref_prod(input int w, input logic [12:0] a,
                                            input logic [12:0] b, input logic s);
      longint mask, sa, sb, r;
      mask = (longint'(1) << w) - 1;
      sa = longint'(a) & mask;
      sb = longint'(b) & mask;
      if (s && sa[w-1]) sa = sa - (longint'(1) << w);
      if (s && sb[w-1]) sb = sb - (longint'(1) << w);
      r = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
      return r[25:0];
   endfunction

   function automatic bit exp_ir(input int i);
      return (!busy[i] && !ev[i]) || (ev[i] && out_ready[i]);
   endfunction

   function automatic logic [12:0] pick(input int w);
      logic [12:0] mask;
      mask = 13'((1 << w) - 1);
      case ($urandom % 4)
         0: return 13'd0;
         1: return mask;
         2: return 13'(1 << (w - 1));
         default: return 13'($urandom) & mask;
      endcase
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [25:0] act, input logic [25:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; ev[i] = 1'b0; rem[i] = 0; ep[i] = 26'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit ir;
            ir = exp_ir(i);
            if (ev[i] && out_ready[i]) ev[i] = 1'b0;
            if (busy[i]) begin
               rem[i]--;
               if (rem[i] == 0) begin
                  busy[i] = 1'b0; ev[i] = 1'b1; ep[i] = pend[i];
               end
            end
            if (in_valid[i] && ir) begin
               busy[i] = 1'b1;
               rem[i]  = wid(i) + 1;
               pend[i] = ref_prod(wid(i), m[i], q[i], sgn[i]);
               nacc[i]++;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk(out_valid[i] == ev[i], $sformatf("out_valid[%0d]", i), 26'(out_valid[i]), 26'(ev[i]));
            chk(in_ready[i] == exp_ir(i), $sformatf("in_ready[%0d]", i), 26'(in_ready[i]), 26'(exp_ir(i)));
            chk(prod[i] == ep[i], $sformatf("product[%0d]", i), prod[i], ep[i]);
         end
      end
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input int hold, input string nm);
      int n;
      @(posedge clk); #1;
      in_valid[0] = 1'b1; m[0] = 13'(a); q[0] = 13'(b); sgn[0] = s; out_ready[0] = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (!out_valid[0] && n < 40) begin
         m[0] = 13'($urandom); q[0] = 13'($urandom); sgn[0] = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      in_valid[0] = 1'b0;
      chk(n == 9, {nm, " latency"}, 26'(n), 26'd9);
      chk(p8 == exp, nm, 26'(p8), 26'(exp));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk(out_valid[0] == 1'b1, {nm, " held valid"}, 26'(out_valid[0]), 26'd1);
         chk(p8 == exp, {nm, " held product"}, 26'(p8), 26'(exp));
         chk(in_ready[0] == 1'b0, {nm, " held in_ready"}, 26'(in_ready[0]), 26'd0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk(out_valid[0] == 1'b0, {nm, " drained"}, 26'(out_valid[0]), 26'd0);
      out_ready[0] = 1'b0;
   endtask

   task automatic rnd(input int i);
      int w, start, cyc;
      w = wid(i);
      start = nacc[i];
      cyc = 0;
      while (nacc[i] - start < 1000 && cyc < 40000) begin
         @(posedge clk); #1;
         cyc++;
         in_valid[i]  = ($urandom % 3) != 0;
         m[i]         = pick(w);
         q[i]         = pick(w);
         sgn[i]       = 1'($urandom);
         out_ready[i] = ($urandom % 4) != 0;
      end
      chk(cyc < 40000, $sformatf("random budget[%0d]", i), 26'(cyc), 26'd40000);
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      repeat (w + 4) @(posedge clk);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; sgn[i] = 1'b0; m[i] = 13'd0; q[i] = 13'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk(out_valid[0] == 1'b0, "reset out_valid", 26'(out_valid[0]), 26'd0);
      chk(in_ready[0] == 1'b1, "reset in_ready", 26'(in_ready[0]), 26'd1);
      chk(p8 == 16'h0000, "reset product", 26'(p8), 26'd0);
      rst_n = 1'b1;

      op8(8'd255, 8'd255, 1'b0, 16'hFE01, 0, "u255x255");
      op8(8'hFD,  8'd5,   1'b1, 16'hFFF1, 5, "s-3x5 backpressure");
      op8(8'h80,  8'h80,  1'b1, 16'h4000, 0, "s-128x-128");
      op8(8'h00,  8'hFF,  1'b1, 16'h0000, 0, "s0x-1");
      op8(8'h80,  8'h7F,  1'b1, 16'hC080, 0, "s-128x127");

      @(posedge clk); #1;
      in_valid[0] = 1'b1; m[0] = 13'd7; q[0] = 13'd9; sgn[0] = 1'b0; out_ready[0] = 1'b1;
      @(posedge clk); #1;
      m[0] = 13'd12; q[0] = 13'd12;
      n = 0;
      while (!out_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
      chk(n == 9, "b2b first latency", 26'(n), 26'd9);
      chk(p8 == 16'd63, "b2b 7x9", 26'(p8), 26'd63);
      @(posedge clk); #1;
      chk(out_valid[0] == 1'b0, "b2b drain", 26'(out_valid[0]), 26'd0);
      chk(in_ready[0] == 1'b0, "b2b no idle", 26'(in_ready[0]), 26'd0);
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
      chk(n == 9, "b2b second latency", 26'(n), 26'd9);
      chk(p8 == 16'd144, "b2b 12x12", 26'(p8), 26'd144);
      @(posedge clk); #1;
      out_ready[0] = 1'b0;

      @(posedge clk); #1;
      in_valid[0] = 1'b1; m[0] = 13'd100; q[0] = 13'd77; sgn[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk(out_valid[0] == 1'b0, "mid reset out_valid", 26'(out_valid[0]), 26'd0);
      chk(in_ready[0] == 1'b1, "mid reset in_ready", 26'(in_ready[0]), 26'd1);
      chk(p8 == 16'h0000, "mid reset product", 26'(p8), 26'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      op8(8'd2, 8'd3, 1'b0, 16'd6, 0, "post-reset 2x3");

      fork
         rnd(0);
         rnd(1);
      join

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
